baseband_test_wrapper: RTL and testbench
========================================

# baseband_test_wrapper

Baseband capture block: takes a 32-bit AXI4-Stream sample stream, frames it in a stream aligner, and writes the samples to memory through a simple DMA write engine. Both units are configured through an AXI4-Lite slave. In the system harness, the block sits behind an AXI4-Lite master at base 0x7940_0000, a stream master on its input, and a memory slave on its AXI4 write port.

## Interface

No parameters. Data width is fixed at 32 bits; address width is fixed at 32 bits.

- clk  in  1  single clock for all logic
- aresetn  in  1  reset; synchronous, active-low
- s_axil_awaddr / awprot / awvalid  in  32/3/1  AXI4-Lite write address; only [8:0] decoded
- s_axil_awready  out  1  write address ready
- s_axil_wdata / wstrb / wvalid  in  32/4/1  AXI4-Lite write data
- s_axil_wready  out  1  write data ready
- s_axil_bresp / bvalid  out  2/1  write response, always OKAY
- s_axil_bready  in  1  write response ready
- s_axil_araddr / arprot / arvalid  in  32/3/1  AXI4-Lite read address
- s_axil_arready  out  1  read address ready
- s_axil_rdata / rresp / rvalid  out  32/2/1  read data, always OKAY
- s_axil_rready  in  1  read data ready
- s_axis_tdata / tvalid  in  32/1  input samples
- s_axis_tready  out  1  input ready
- m_axi_awaddr / awlen / awsize / awburst / awvalid  out  32/8/3/2/1  memory write address; fixed awlen=0, awsize=2, awburst=INCR
- m_axi_awready  in  1  memory write address ready
- m_axi_wdata / wstrb / wlast / wvalid  out  32/4/1/1  memory write data; wstrb=0xF, wlast=1
- m_axi_wready  in  1  memory write data ready
- m_axi_bresp / bvalid  in  2/1  memory write response
- m_axi_bready  out  1  memory write response ready

## Operation

- Address decode uses offset[8]: 0 selects the DMA, 1 selects the aligner. Upper address bits are ignored.
- Unmapped reads return 0; unmapped writes are dropped. Both complete with an OKAY response.

DMA registers (offsets 0x000–0x024):
- 0x00 en [0], R/W
- 0x10 base [31:0], R/W, byte address
- 0x14 length [31:0], R/W; one pass writes length+1 words
- 0x18 cycles [31:0], R/W; number of passes = cycles+1
- 0x20 write (any data): start
- 0x20 / 0x24 read: remaining[31:0] / remaining[63:32]

Aligner registers (offsets 0x100–0x10C):
- 0x100 en [0], R/W
- 0x104 count, read-only; total samples passed since reset
- 0x10C maxCnt [31:0], R/W

Aligner behaviour:
- en=0: s_axis_tready=0; input is stalled and no data is lost.
- en=1: combinational pass-through to the DMA: tready = DMA ready; tdata passes unchanged.
- Internal tlast pulses on every maxCnt-th accepted sample; maxCnt=0 produces no tlast. The DMA ignores tlast.

DMA behaviour:
- Start with en=1: remaining ← (length+1)·(cycles+1) (64-bit); word index k ← 0.
- Start with en=0: ignored.
- Start while busy: reloads remaining and restarts at k=0.
- Busy means remaining≠0. While busy, the engine accepts one sample, then issues a single-beat write of that sample to base + 4·(k mod (length+1)).
- On B handshake: remaining −1 and k +1. Any bresp value counts as done.
- Idle: DMA ready=0.

DMA state machine: IDLE → (start, en) → ACCEPT → (sample handshake) → WRITE (awvalid and wvalid asserted together; each deasserts independently after its handshake) → RESP (bready=1) → (bvalid) → ACCEPT if remaining>0 after decrement, otherwise IDLE.

Clearing DMA en mid-transfer:
- The current write completes.
- The engine then returns to IDLE with remaining held (nonzero readback).

## Timing

- Reset: all registers, counters and remaining go to 0. All valid/ready outputs go to 0, except s_axil_awready/wready/arready, which are 1 one cycle after reset release.
- Reset mid-transfer: outstanding memory transactions are abandoned; no B response is awaited.
- AXI4-Lite write: AW and W are accepted in the same cycle only when both are valid. bvalid asserts the next cycle and is held until bready. No new AW/W is accepted while bvalid=1.
- AXI4-Lite read: rvalid asserts the cycle after the AR handshake and is held until rready.
- Register writes take effect the cycle after the handshake.
- remaining reads 0x20 reflect the value as of the AR handshake cycle.
- Sample-to-AW/W latency is 1 cycle.
- At most one memory write is outstanding; throughput is ≥3 cycles per word.

## Test plan

- Reset then read every register → all 0; s_axis_tready=0.
- Configure aligner maxCnt=0x20, en=1; DMA en=1, base=0, length=10, cycles=0; write 0x20; stream 0,1,2,…,99 → memory words 0..10 = 0x0…0x0A; remaining reads 11 → 0; tready=0 after the 11th sample; aligner count=11.
- Same setup with aligner en=0 → stream stalls; remaining stays 11; memory is untouched until aligner en=1.
- length=3, cycles=1, base=0x40 → 8 writes, to 0x40,0x44,0x48,0x4C,0x40,…; final words hold samples 4..7.
- Start with DMA en=0 → remaining stays 0; no AW issued.
- Clear DMA en after 2 words with length=9 → exactly 3 words written (including the in-flight one); remaining=7 held.

Source files
------------

// File: rtl/baseband_test_wrapper.sv
`timescale 1ns/1ps
// baseband_test_wrapper: AXI4-Stream capture through a framing aligner
// into a single-beat DMA write engine, both configured over AXI4-Lite.
module baseband_test_wrapper (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [31:0] s_axil_awaddr,
    input  logic [2:0]  s_axil_awprot,
    input  logic        s_axil_awvalid,
    output logic        s_axil_awready,
    input  logic [31:0] s_axil_wdata,
    input  logic [3:0]  s_axil_wstrb,
    input  logic        s_axil_wvalid,
    output logic        s_axil_wready,
    output logic [1:0]  s_axil_bresp,
    output logic        s_axil_bvalid,
    input  logic        s_axil_bready,
    input  logic [31:0] s_axil_araddr,
    input  logic [2:0]  s_axil_arprot,
    input  logic        s_axil_arvalid,
    output logic        s_axil_arready,
    output logic [31:0] s_axil_rdata,
    output logic [1:0]  s_axil_rresp,
    output logic        s_axil_rvalid,
    input  logic        s_axil_rready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_RESP
    } dma_state_e;

    // AXI4-Lite channel state
    logic        ready_q, ready_d;
    logic        bvalid_q, bvalid_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;

    // DMA configuration and progress
    logic        dma_en_q, dma_en_d;
    logic [31:0] base_q, base_d;
    logic [31:0] len_q, len_d;
    logic [31:0] cyc_q, cyc_d;
    logic [63:0] rem_q, rem_d;
    logic [31:0] idx_q, idx_d;
    dma_state_e  state_q, state_d;
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;

    // Aligner configuration and counters
    logic        al_en_q, al_en_d;
    logic [31:0] al_cnt_q, al_cnt_d;
    logic [31:0] max_q, max_d;
    logic [31:0] beat_q, beat_d;
    logic        al_tlast;

    logic        lite_open;
    logic        wr_fire;
    logic        rd_fire;
    logic        wr_dma;
    logic        wr_al;
    logic [7:0]  waddr;
    logic [7:0]  raddr;
    logic        start;
    logic        dma_ready;
    logic        smp_fire;
    logic [32:0] len_p1;
    logic [32:0] cyc_p1;
    logic [65:0] total_prod;
    logic [63:0] rem_dec;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{s_axil_awaddr[31:9], s_axil_awprot,
                           s_axil_wstrb, s_axil_araddr[31:9],
                           s_axil_arprot, m_axi_bresp,
                           total_prod[65:64]};

    // AW and W are only taken together, and never while B is pending
    assign lite_open      = ready_q & ~bvalid_q;
    assign s_axil_awready = lite_open &
                            (s_axil_wvalid | ~s_axil_awvalid);
    assign s_axil_wready  = lite_open &
                            (s_axil_awvalid | ~s_axil_wvalid);
    assign wr_fire        = lite_open & s_axil_awvalid & s_axil_wvalid;
    assign s_axil_arready = ready_q & ~rvalid_q;
    assign rd_fire        = s_axil_arvalid & s_axil_arready;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = 2'b00;

    assign waddr  = s_axil_awaddr[7:0];
    assign raddr  = s_axil_araddr[7:0];
    assign wr_dma = wr_fire & ~s_axil_awaddr[8];
    assign wr_al  = wr_fire & s_axil_awaddr[8];
    assign start  = wr_dma & (waddr == 8'h20) & dma_en_q;

    assign len_p1     = {1'b0, len_q} + 33'd1;
    assign cyc_p1     = {1'b0, cyc_q} + 33'd1;
    assign total_prod = len_p1 * cyc_p1;
    assign rem_dec    = rem_q - 64'd1;

    // The aligner is a gated pass-through in front of the DMA
    assign dma_ready     = (state_q == ST_ACCEPT) & dma_en_q;
    assign s_axis_tready = al_en_q & dma_ready;
    assign smp_fire      = s_axis_tvalid & s_axis_tready;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'd2;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = aw_pend_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_wvalid  = w_pend_q;
    assign m_axi_bready  = (state_q == ST_RESP);

    // Lite handshake tracking and read capture at the AR handshake
    always_comb begin
        ready_d  = 1'b1;
        bvalid_d = bvalid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

    // Register read decode; offset bit 8 picks the aligner
    always_comb begin
        rd_mux = 32'd0;
        if (!s_axil_araddr[8]) begin
            case (raddr)
                8'h00:   rd_mux = {31'd0, dma_en_q};
                8'h10:   rd_mux = base_q;
                8'h14:   rd_mux = len_q;
                8'h18:   rd_mux = cyc_q;
                8'h20:   rd_mux = rem_q[31:0];
                8'h24:   rd_mux = rem_q[63:32];
                default: rd_mux = 32'd0;
            endcase
        end else begin
            case (raddr)
                8'h00:   rd_mux = {31'd0, al_en_q};
                8'h04:   rd_mux = al_cnt_q;
                8'h0C:   rd_mux = max_q;
                default: rd_mux = 32'd0;
            endcase
        end
    end

    // Config register writes; unmapped offsets are dropped
    always_comb begin
        dma_en_d = dma_en_q;
        base_d   = base_q;
        len_d    = len_q;
        cyc_d    = cyc_q;
        al_en_d  = al_en_q;
        max_d    = max_q;
        if (wr_dma) begin
            case (waddr)
                8'h00:   dma_en_d = s_axil_wdata[0];
                8'h10:   base_d   = s_axil_wdata;
                8'h14:   len_d    = s_axil_wdata;
                8'h18:   cyc_d    = s_axil_wdata;
                default: ;
            endcase
        end
        if (wr_al) begin
            case (waddr)
                8'h00:   al_en_d = s_axil_wdata[0];
                8'h0C:   max_d   = s_axil_wdata;
                default: ;
            endcase
        end
    end

    // Aligner sample count and frame marker every maxCnt samples
    always_comb begin
        al_cnt_d = al_cnt_q;
        beat_d   = beat_q;
        al_tlast = smp_fire & (max_q != 32'd0) &
                   (beat_q + 32'd1 == max_q);
        if (smp_fire) begin
            al_cnt_d = al_cnt_q + 32'd1;
            beat_d   = al_tlast ? 32'd0 : beat_q + 32'd1;
        end
    end

    // DMA engine: accept one sample, write it, wait for B
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_ACCEPT: begin
                if (smp_fire) begin
                    data_d    = s_axis_tdata;
                    addr_d    = base_q + {idx_q[29:0], 2'b00};
                    aw_pend_d = 1'b1;
                    w_pend_d  = 1'b1;
                    state_d   = ST_WRITE;
                end else if (!dma_en_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (aw_pend_q && m_axi_awready) begin
                    aw_pend_d = 1'b0;
                end
                if (w_pend_q && m_axi_wready) begin
                    w_pend_d = 1'b0;
                end
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    rem_d = rem_dec;
                    idx_d = (idx_q == len_q) ? 32'd0
                                             : idx_q + 32'd1;
                    if (rem_dec != 64'd0 && dma_en_q) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            rem_d = total_prod[63:0];
            idx_d = 32'd0;
            if (state_d == ST_IDLE && total_prod[63:0] != 64'd0) begin
                state_d = ST_ACCEPT;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ready_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            dma_en_q  <= 1'b0;
            base_q    <= 32'd0;
            len_q     <= 32'd0;
            cyc_q     <= 32'd0;
            rem_q     <= 64'd0;
            idx_q     <= 32'd0;
            state_q   <= ST_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= 32'd0;
            data_q    <= 32'd0;
            al_en_q   <= 1'b0;
            al_cnt_q  <= 32'd0;
            max_q     <= 32'd0;
            beat_q    <= 32'd0;
        end else begin
            ready_q   <= ready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            dma_en_q  <= dma_en_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cyc_q     <= cyc_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            al_en_q   <= al_en_d;
            al_cnt_q  <= al_cnt_d;
            max_q     <= max_d;
            beat_q    <= beat_d;
        end
    end

endmodule

// File: tb/tb_baseband_test_wrapper.sv
`timescale 1ns/1ps
// tb_baseband_test_wrapper: scoreboarded stream-to-memory capture bench
// with an AXI4-Lite driver and a single-outstanding memory slave model.
module tb_baseband_test_wrapper;

    localparam logic [31:0] BASE = 32'h7940_0000;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [31:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    always #5 clk = ~clk;

    baseband_test_wrapper dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awburst  (m_axi_awburst),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_wr = 0;
    int          n_b = 0;
    int          smp = 0;
    bit          stream_on = 0;
    int          bdelay = 0;
    logic [31:0] mbase = 32'd0;
    int          mlen = 0;
    int          widx = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD_BEEF;
    endfunction

    // Stream source: push the expected memory write for every accepted sample
    initial begin
        bit fire;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        forever begin
            @(negedge clk);
            fire = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (fire) begin
                sb.push_back('{addr: mbase + 32'(4 * (widx % (mlen + 1))),
                               data: s_axis_tdata});
                widx++;
                smp++;
                s_axis_tdata = 32'(smp);
            end
            s_axis_tvalid = stream_on;
        end
    end

    // Memory slave: always ready, B after bdelay cycles, random bresp
    initial begin
        wr_t e;
        int  t;
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (m_axi_awvalid && m_axi_wvalid) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_wr", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("mem_addr", m_axi_awaddr, e.addr);
                    check("mem_data", m_axi_wdata, e.data);
                end
                check("aw_attr", {m_axi_awlen, m_axi_awsize, m_axi_awburst,
                                  m_axi_wstrb, m_axi_wlast},
                      {8'd0, 3'd2, 2'd1, 4'hF, 1'b1});
                mem[m_axi_awaddr] = m_axi_wdata;
                n_wr++;
                @(posedge clk);
                #1;
                for (int i = 0; i < bdelay; i++) begin
                    @(posedge clk);
                    #1;
                end
                m_axi_bresp  = 2'($urandom_range(0, 3));
                m_axi_bvalid = 1'b1;
                t = 0;
                while (1) begin
                    @(negedge clk);
                    if (m_axi_bready) break;
                    t++;
                    if (t > 200) begin
                        check("bready_timeout", 1'b0, 1'b1);
                        break;
                    end
                end
                @(posedge clk);
                #1;
                m_axi_bvalid = 1'b0;
                n_b++;
            end
        end
    end

    task automatic lite_wr(input logic [31:0] a, input logic [31:0] d);
        int t;
        @(negedge clk);
        s_axil_awaddr  = a;
        s_axil_wdata   = d;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        #1;
        t = 0;
        while (!(s_axil_awready && s_axil_wready)) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 50) begin
                check("lite_aw_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b1;
        t = 0;
        while (!s_axil_bvalid) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 50) begin
                check("lite_b_timeout", 1'b0, 1'b1);
                break;
            end
        end
        check("lite_bresp", s_axil_bresp, 2'b00);
        @(posedge clk);
        #1;
        s_axil_bready = 1'b0;
    endtask

    task automatic lite_rd(input logic [31:0] a, output logic [31:0] d);
        int t;
        @(negedge clk);
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        #1;
        t = 0;
        while (!s_axil_arready) begin
            @(negedge clk);
            #1;
            t++;
            if (t > 50) begin
                check("lite_ar_timeout", 1'b0, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b1;
        t = 0;
        while (!s_axil_rvalid) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 50) begin
                check("lite_r_timeout", 1'b0, 1'b1);
                break;
            end
        end
        d = s_axil_rdata;
        check("lite_rresp", s_axil_rresp, 2'b00);
        @(posedge clk);
        #1;
        s_axil_rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off,
                          input logic [31:0] exp);
        logic [31:0] d;
        lite_rd(BASE + off, d);
        check(tag, d, exp);
    endtask

    task automatic do_reset;
        stream_on = 0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        smp          = 0;
        s_axis_tdata = 32'd0;
        sb.delete();
        mem.delete();
        n_wr = 0;
        n_b  = 0;
        widx = 0;
    endtask

    task automatic setup(input bit al_en, input bit dma_en,
                         input logic [31:0] b, input int len,
                         input int cyc);
        lite_wr(BASE + 32'h10C, 32'h20);
        lite_wr(BASE + 32'h100, {31'd0, al_en});
        lite_wr(BASE + 32'h000, {31'd0, dma_en});
        lite_wr(BASE + 32'h010, b);
        lite_wr(BASE + 32'h014, 32'(len));
        lite_wr(BASE + 32'h018, 32'(cyc));
        mbase = b;
        mlen  = len;
        widx  = 0;
        lite_wr(BASE + 32'h020, 32'hFFFF_FFFF);
    endtask

    task automatic wait_b(input int target, input int budget);
        int t;
        t = 0;
        while (n_b < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("wait_b", 64'(n_b), 64'(target));
    endtask

    initial begin
        aresetn        = 1'b0;
        s_axil_awaddr  = 32'd0;
        s_axil_awprot  = 3'd0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = 32'd0;
        s_axil_wstrb   = 4'h0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;
        s_axil_araddr  = 32'd0;
        s_axil_arprot  = 3'd0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;

        do_reset();
        check("rst_awready", s_axil_awready, 1'b1);
        check("rst_wready", s_axil_wready, 1'b1);
        check("rst_arready", s_axil_arready, 1'b1);
        check("rst_valids", {s_axil_bvalid, s_axil_rvalid,
                             m_axi_awvalid, m_axi_wvalid,
                             m_axi_bready}, 5'd0);
        check("rst_tready", s_axis_tready, 1'b0);
        rd_chk("rst_dma_en", 32'h000, 32'd0);
        rd_chk("rst_base", 32'h010, 32'd0);
        rd_chk("rst_len", 32'h014, 32'd0);
        rd_chk("rst_cyc", 32'h018, 32'd0);
        rd_chk("rst_rem_lo", 32'h020, 32'd0);
        rd_chk("rst_rem_hi", 32'h024, 32'd0);
        rd_chk("rst_al_en", 32'h100, 32'd0);
        rd_chk("rst_al_cnt", 32'h104, 32'd0);
        rd_chk("rst_max", 32'h10C, 32'd0);

        lite_wr(BASE + 32'h008, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 32'h008, 32'd0);
        lite_wr(32'hFFFF_FE10, 32'h1234_5678);
        rd_chk("upper_bits_ignored", 32'h010, 32'h1234_5678);
        lite_wr(BASE + 32'h104, 32'd5);
        rd_chk("count_read_only", 32'h104, 32'd0);
        lite_wr(BASE + 32'h10C, 32'hABCD_0123);
        rd_chk("max_rw", 32'h10C, 32'hABCD_0123);

        // Basic single pass of 11 words
        do_reset();
        bdelay = 1;
        setup(1'b1, 1'b1, 32'd0, 10, 0);
        rd_chk("a_rem_lo", 32'h020, 32'd11);
        rd_chk("a_rem_hi", 32'h024, 32'd0);
        stream_on = 1;
        wait_b(11, 600);
        repeat (10) @(posedge clk);
        #1;
        check("a_tready_done", s_axis_tready, 1'b0);
        check("a_n_wr", 64'(n_wr), 64'd11);
        rd_chk("a_rem_end", 32'h020, 32'd0);
        rd_chk("a_al_cnt", 32'h104, 32'd11);
        for (int i = 0; i <= 10; i++) begin
            check("a_mem", mem_rd(32'(4 * i)), 32'(i));
        end
        check("a_sb_empty", 64'(sb.size()), 64'd0);

        // Aligner disabled: stream stalls until enabled
        do_reset();
        bdelay = 0;
        setup(1'b0, 1'b1, 32'd0, 10, 0);
        stream_on = 1;
        repeat (30) @(posedge clk);
        #1;
        check("b_tready_stall", s_axis_tready, 1'b0);
        check("b_no_wr", 64'(n_wr), 64'd0);
        rd_chk("b_rem_held", 32'h020, 32'd11);
        lite_wr(BASE + 32'h100, 32'd1);
        wait_b(11, 600);
        for (int i = 0; i <= 10; i++) begin
            check("b_mem", mem_rd(32'(4 * i)), 32'(i));
        end
        check("b_sb_empty", 64'(sb.size()), 64'd0);

        // Two passes of four words at base 0x40
        do_reset();
        bdelay = 2;
        setup(1'b1, 1'b1, 32'h40, 3, 1);
        rd_chk("c_rem", 32'h020, 32'd8);
        stream_on = 1;
        wait_b(8, 600);
        repeat (5) @(posedge clk);
        #1;
        check("c_n_wr", 64'(n_wr), 64'd8);
        for (int i = 0; i < 4; i++) begin
            check("c_mem", mem_rd(32'h40 + 32'(4 * i)), 32'(4 + i));
        end
        rd_chk("c_rem_end", 32'h020, 32'd0);

        // Start with DMA disabled is ignored
        do_reset();
        bdelay = 0;
        setup(1'b1, 1'b0, 32'd0, 10, 0);
        rd_chk("d_rem", 32'h020, 32'd0);
        stream_on = 1;
        repeat (20) @(posedge clk);
        #1;
        check("d_no_wr", 64'(n_wr), 64'd0);
        check("d_tready", s_axis_tready, 1'b0);
        rd_chk("d_al_cnt", 32'h104, 32'd0);

        // Clearing DMA en while the third write is in flight
        do_reset();
        bdelay = 10;
        setup(1'b1, 1'b1, 32'd0, 9, 0);
        stream_on = 1;
        begin
            int t;
            t = 0;
            while (n_wr < 3 && t < 300) begin
                @(posedge clk);
                #1;
                t++;
            end
            check("e_third_aw", 64'(n_wr), 64'd3);
        end
        lite_wr(BASE + 32'h000, 32'd0);
        wait_b(3, 300);
        repeat (20) @(posedge clk);
        #1;
        check("e_n_wr", 64'(n_wr), 64'd3);
        check("e_tready", s_axis_tready, 1'b0);
        rd_chk("e_rem_held", 32'h020, 32'd7);
        rd_chk("e_al_cnt", 32'h104, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("e_mem", mem_rd(32'(4 * i)), 32'(i));
        end
        check("e_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
